datapath_fetch_router: RTL and testbench
========================================

# datapath_fetch_router

Registered, handshaked successor to the combinational P-RAM/V-RAM data router. It accepts one mode-tagged read request at a time and issues the read to program RAM (P-RAM) or variable RAM (V-RAM). It waits a parametrised synchronous-RAM read latency, then captures the returned word into the instruction, peek or load holding register. The word is held there, with a per-destination valid flag, until the consumer acknowledges it. It sits between the fetch/decode front end and the two on-chip RAMs.

## Interface

Parameters:
- WORD_SIZE, 16: data word width.
- ADDR_SIZE, 8: RAM address width (both RAMs).
- MODE_SELECT_SIZE, 3: request mode width.
- RAM_LATENCY, 1: RAM read latency in cycles, legal 1..4. It is the number of cycles from the enable being sampled to the data being valid.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: request offered.
- req_ready, out, 1: router can accept a request.
- req_mode, in, MODE_SELECT_SIZE: routing mode.
- req_addr, in, ADDR_SIZE: read address.
- p_ram_en, out, 1: P-RAM read enable.
- p_ram_addr, out, ADDR_SIZE: P-RAM address.
- v_ram_en, out, 1: V-RAM read enable.
- v_ram_addr, out, ADDR_SIZE: V-RAM address.
- p_ram_data, in, WORD_SIZE: P-RAM read data.
- v_ram_data, in, WORD_SIZE: V-RAM read data.
- instruction, out, WORD_SIZE: instruction holding register.
- instruction_valid, out, 1: instruction holds an unacknowledged word.
- peek, out, WORD_SIZE: peek holding register.
- peek_valid, out, 1: peek holds an unacknowledged word.
- load, out, WORD_SIZE: load holding register.
- load_valid, out, 1: load holds an unacknowledged word.
- resp_ready, in, 1: consumer acknowledges the held word.
- mode_err, out, 1: one-cycle pulse on acceptance of an illegal mode.

## Operation

Mode map:
- 0: P-RAM → instruction.
- 1: P-RAM → peek.
- 2: P-RAM → load.
- 3: V-RAM → load.
- 4..max: treated as mode 0; mode_err pulses for one cycle, in the cycle after acceptance.

State machine, IDLE → ISSUE → WAIT → HOLD → IDLE:
- IDLE: req_ready=1. On req_valid at an edge, latch mode and address → ISSUE.
- ISSUE, 1 cycle: assert the selected RAM's en with the latched address. The other RAM's en=0 and its address is held. → WAIT, with a latency counter of width clog2(RAM_LATENCY+1) loaded with 0.
- WAIT, RAM_LATENCY cycles: both en=0. On the edge ending the last WAIT cycle, sample the selected RAM's data into the destination register, set that destination's valid → HOLD.
- HOLD: exactly one valid is high. On an edge with resp_ready=1, clear that valid → IDLE.

Register behaviour:
- The holding registers keep their last value after acknowledgement; only the valid flag clears.
- Registers not targeted by a request are never written.
- The addresses driven on p_ram_addr and v_ram_addr are registered. Both hold their last value when idle.
- req_ready=0 in every state except IDLE. req_valid, req_mode and req_addr are ignored outside IDLE.
- resp_ready outside HOLD has no effect.

## Timing

- Reset, asynchronous and immediate: state=IDLE, req_ready=1. All en, addr, data registers and valid flags are 0; mode_err=0.
- Reset mid-operation aborts the request. Nothing is captured, and no valid appears after release.
- The request is accepted at edge E0. en is high for exactly the one cycle between E0 and E1.
- Data is captured at edge E(1+RAM_LATENCY). Valid is high from that edge.
- Acceptance to valid is RAM_LATENCY+1 edges.
- If resp_ready is already high when valid rises, valid lasts exactly one cycle.
- The next request can be accepted at the edge after the acknowledging edge. Peak throughput is one request per RAM_LATENCY+3 cycles.
- mode_err is high in the ISSUE cycle only.

## Test plan

- Reset: hold rst_n=0 with random inputs → all outputs 0, req_ready=1. Release, then idle for 5 cycles → no en and no valid.
- Mode 0, addr 0x12, RAM_LATENCY=1, P-RAM returns 0xBEEF → p_ram_en high for 1 cycle with addr 0x12. instruction=0xBEEF and instruction_valid are high 2 edges after acceptance. peek and load are unchanged.
- Mode 3, addr 0x40, RAM_LATENCY=3, V-RAM returns 0x1234, resp_ready held 0 for 10 cycles → load=0x1234. load_valid stays high until resp_ready=1, then drops; load holds 0x1234. v_ram_en pulses once, and p_ram_en never asserts.
- Modes 1 and 2 back-to-back with resp_ready=1 throughout → peek, then load, are each updated with one-cycle valids. The second acceptance happens exactly RAM_LATENCY+3 cycles after the first, and req_ready is 0 in between.
- Mode 6, P-RAM returns 0x00AA → mode_err pulses for 1 cycle, and instruction=0x00AA with instruction_valid.
- rst_n asserted during WAIT → state returns to IDLE. No valid is asserted after release, and the stale RAM data is not captured.

Source files
------------

// File: rtl/datapath_fetch_router.sv
// datapath_fetch_router
// Registered, handshaked router between the fetch/decode front end and the
// two on-chip synchronous RAMs (P-RAM and V-RAM). Accepts one mode-tagged
// read request at a time and issues it to the RAM the mode selects. It then
// waits RAM_LATENCY cycles and captures the returned word into the
// instruction, peek or load holding register. The word stays there, flagged
// valid, until the consumer acknowledges it with resp_ready.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready/req_mode/req_addr  request handshake (IDLE only)
//   p_ram_en/p_ram_addr, p_ram_data     P-RAM read port
//   v_ram_en/v_ram_addr, v_ram_data     V-RAM read port
//   instruction/peek/load (+ _valid)    holding registers and valid flags
//   resp_ready                          consumer acknowledge (HOLD only)
//   mode_err                            one-cycle pulse for an illegal mode
module datapath_fetch_router #(
    parameter int WORD_SIZE        = 16,
    parameter int ADDR_SIZE        = 8,
    parameter int MODE_SELECT_SIZE = 3,
    parameter int RAM_LATENCY      = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [MODE_SELECT_SIZE-1:0] req_mode,
    input  logic [ADDR_SIZE-1:0]        req_addr,
    output logic                        p_ram_en,
    output logic [ADDR_SIZE-1:0]        p_ram_addr,
    output logic                        v_ram_en,
    output logic [ADDR_SIZE-1:0]        v_ram_addr,
    input  logic [WORD_SIZE-1:0]        p_ram_data,
    input  logic [WORD_SIZE-1:0]        v_ram_data,
    output logic [WORD_SIZE-1:0]        instruction,
    output logic                        instruction_valid,
    output logic [WORD_SIZE-1:0]        peek,
    output logic                        peek_valid,
    output logic [WORD_SIZE-1:0]        load,
    output logic                        load_valid,
    input  logic                        resp_ready,
    output logic                        mode_err
);

    localparam int CNT_W = $clog2(RAM_LATENCY + 1);
    // Counter value in the final WAIT cycle; data is captured on the edge ending it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LATENCY - 1);

    localparam logic [MODE_SELECT_SIZE-1:0] MODE_P_INSTR = MODE_SELECT_SIZE'(0);
    localparam logic [MODE_SELECT_SIZE-1:0] MODE_P_PEEK  = MODE_SELECT_SIZE'(1);
    localparam logic [MODE_SELECT_SIZE-1:0] MODE_P_LOAD  = MODE_SELECT_SIZE'(2);
    localparam logic [MODE_SELECT_SIZE-1:0] MODE_V_LOAD  = MODE_SELECT_SIZE'(3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DST_INSTR = 2'd0,
        DST_PEEK  = 2'd1,
        DST_LOAD  = 2'd2
    } dest_t;

    state_t                 state_q, state_d;
    dest_t                  dest_q, dest_d;
    logic                   sel_v_q, sel_v_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   req_ready_q, req_ready_d;
    logic                   p_en_q, p_en_d;
    logic                   v_en_q, v_en_d;
    logic [ADDR_SIZE-1:0]   p_addr_q, p_addr_d;
    logic [ADDR_SIZE-1:0]   v_addr_q, v_addr_d;
    logic [WORD_SIZE-1:0]   instr_q, instr_d;
    logic [WORD_SIZE-1:0]   peek_q, peek_d;
    logic [WORD_SIZE-1:0]   load_q, load_d;
    logic                   instr_vld_q, instr_vld_d;
    logic                   peek_vld_q, peek_vld_d;
    logic                   load_vld_q, load_vld_d;
    logic                   mode_err_q, mode_err_d;
    logic [WORD_SIZE-1:0]   rdata_s;

    // Next-state, request decode, RAM issue and capture logic.
    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        sel_v_d     = sel_v_q;
        cnt_d       = cnt_q;
        p_en_d      = 1'b0;
        v_en_d      = 1'b0;
        p_addr_d    = p_addr_q;
        v_addr_d    = v_addr_q;
        instr_d     = instr_q;
        peek_d      = peek_q;
        load_d      = load_q;
        instr_vld_d = instr_vld_q;
        peek_vld_d  = peek_vld_q;
        load_vld_d  = load_vld_q;
        mode_err_d  = 1'b0;
        rdata_s     = sel_v_q ? v_ram_data : p_ram_data;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_ISSUE;
                    sel_v_d = 1'b0;
                    case (req_mode)
                        MODE_P_INSTR: dest_d = DST_INSTR;
                        MODE_P_PEEK:  dest_d = DST_PEEK;
                        MODE_P_LOAD:  dest_d = DST_LOAD;
                        MODE_V_LOAD: begin
                            dest_d  = DST_LOAD;
                            sel_v_d = 1'b1;
                        end
                        default: begin
                            // Illegal modes fall back to an instruction fetch.
                            dest_d     = DST_INSTR;
                            mode_err_d = 1'b1;
                        end
                    endcase
                    // Enable and address are registered here so they appear
                    // during the ISSUE cycle; the unselected RAM keeps its address.
                    if (sel_v_d) begin
                        v_en_d   = 1'b1;
                        v_addr_d = req_addr;
                    end else begin
                        p_en_d   = 1'b1;
                        p_addr_d = req_addr;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(0);
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD;
                    case (dest_q)
                        DST_INSTR: begin
                            instr_d     = rdata_s;
                            instr_vld_d = 1'b1;
                        end
                        DST_PEEK: begin
                            peek_d     = rdata_s;
                            peek_vld_d = 1'b1;
                        end
                        DST_LOAD: begin
                            load_d     = rdata_s;
                            load_vld_d = 1'b1;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (resp_ready) begin
                    state_d     = ST_IDLE;
                    instr_vld_d = 1'b0;
                    peek_vld_d  = 1'b0;
                    load_vld_d  = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dest_q      <= DST_INSTR;
            sel_v_q     <= 1'b0;
            cnt_q       <= CNT_W'(0);
            req_ready_q <= 1'b1;
            p_en_q      <= 1'b0;
            v_en_q      <= 1'b0;
            p_addr_q    <= ADDR_SIZE'(0);
            v_addr_q    <= ADDR_SIZE'(0);
            instr_q     <= WORD_SIZE'(0);
            peek_q      <= WORD_SIZE'(0);
            load_q      <= WORD_SIZE'(0);
            instr_vld_q <= 1'b0;
            peek_vld_q  <= 1'b0;
            load_vld_q  <= 1'b0;
            mode_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            sel_v_q     <= sel_v_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            p_en_q      <= p_en_d;
            v_en_q      <= v_en_d;
            p_addr_q    <= p_addr_d;
            v_addr_q    <= v_addr_d;
            instr_q     <= instr_d;
            peek_q      <= peek_d;
            load_q      <= load_d;
            instr_vld_q <= instr_vld_d;
            peek_vld_q  <= peek_vld_d;
            load_vld_q  <= load_vld_d;
            mode_err_q  <= mode_err_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign p_ram_en          = p_en_q;
    assign p_ram_addr        = p_addr_q;
    assign v_ram_en          = v_en_q;
    assign v_ram_addr        = v_addr_q;
    assign instruction       = instr_q;
    assign instruction_valid = instr_vld_q;
    assign peek              = peek_q;
    assign peek_valid        = peek_vld_q;
    assign load              = load_q;
    assign load_valid        = load_vld_q;
    assign mode_err          = mode_err_q;

endmodule

// File: tb/tb_datapath_fetch_router.sv
// Testbench for datapath_fetch_router. Two instances run side by side:
// index 0 with RAM_LATENCY=1 and index 1 with RAM_LATENCY=3. Each has a
// latency-accurate RAM model that drives 16'hDEAD whenever no read is due.
module tb_datapath_fetch_router;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            req_valid = 2'b00;
    logic [1:0]            req_ready;
    logic [1:0][2:0]       req_mode = '0;
    logic [1:0][7:0]       req_addr = '0;
    logic [1:0]            p_ram_en, v_ram_en;
    logic [1:0][7:0]       p_ram_addr, v_ram_addr;
    logic [1:0][15:0]      p_ram_data, v_ram_data;
    logic [1:0][15:0]      instruction, peek, load;
    logic [1:0]            instruction_valid, peek_valid, load_valid;
    logic [1:0]            resp_ready = 2'b00;
    logic [1:0]            mode_err;

    logic [15:0] pmem [256];
    logic [15:0] vmem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = 2 * g + 1;
        logic [3:0]      p_hist = 4'd0;
        logic [3:0]      v_hist = 4'd0;
        logic [3:0][7:0] p_ah = '0;
        logic [3:0][7:0] v_ah = '0;

        // RAM model: enable sampled at an edge, word valid LAT-1 edges later.
        always @(posedge clk) begin
            p_hist <= {p_hist[2:0], p_ram_en[g]};
            v_hist <= {v_hist[2:0], v_ram_en[g]};
            p_ah   <= {p_ah[2:0], p_ram_addr[g]};
            v_ah   <= {v_ah[2:0], v_ram_addr[g]};
        end

        assign p_ram_data[g] = p_hist[LAT-1] ? pmem[p_ah[LAT-1]] : 16'hDEAD;
        assign v_ram_data[g] = v_hist[LAT-1] ? vmem[v_ah[LAT-1]] : 16'hDEAD;

        datapath_fetch_router #(
            .WORD_SIZE(16), .ADDR_SIZE(8), .MODE_SELECT_SIZE(3), .RAM_LATENCY(LAT)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_mode(req_mode[g]), .req_addr(req_addr[g]),
            .p_ram_en(p_ram_en[g]), .p_ram_addr(p_ram_addr[g]),
            .v_ram_en(v_ram_en[g]), .v_ram_addr(v_ram_addr[g]),
            .p_ram_data(p_ram_data[g]), .v_ram_data(v_ram_data[g]),
            .instruction(instruction[g]), .instruction_valid(instruction_valid[g]),
            .peek(peek[g]), .peek_valid(peek_valid[g]),
            .load(load[g]), .load_valid(load_valid[g]),
            .resp_ready(resp_ready[g]), .mode_err(mode_err[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, pcnt, vcnt, acc1, acc2, zeros, pv, lv, merr;
        logic hold_ok, quiet;

        for (int i = 0; i < 256; i++) begin
            pmem[i] = 16'h0;
            vmem[i] = 16'h0;
        end
        pmem[8'h12] = 16'hBEEF;
        vmem[8'h40] = 16'h1234;
        pmem[8'h21] = 16'h1111;
        pmem[8'h22] = 16'h2222;
        pmem[8'h33] = 16'h00AA;
        pmem[8'h50] = 16'h5555;

        // ---- reset with random inputs ----
        for (int i = 0; i < 3; i++) begin
            req_valid  = 2'($urandom);
            req_mode   = 6'($urandom);
            req_addr   = 16'($urandom);
            resp_ready = 2'($urandom);
            @(negedge clk);
        end
        check_eq("rst_req_ready", 32'(req_ready), 32'h3);
        check_eq("rst_en", 32'({p_ram_en, v_ram_en}), 32'h0);
        check_eq("rst_addr", 32'({p_ram_addr, v_ram_addr}), 32'h0);
        check_eq("rst_data", 32'(instruction[0] | instruction[1] | peek[0] | peek[1]
                                 | load[0] | load[1]), 32'h0);
        check_eq("rst_valid", 32'({instruction_valid, peek_valid, load_valid, mode_err}), 32'h0);
        req_valid  = 2'b00;
        req_mode   = '0;
        req_addr   = '0;
        resp_ready = 2'b00;
        rst_n      = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("idle_quiet", 32'({p_ram_en, v_ram_en, instruction_valid, peek_valid,
                                        load_valid}), 32'h0);
        end

        // ---- mode 0, addr 0x12, latency 1 ----
        req_valid[0] = 1'b1; req_mode[0] = 3'd0; req_addr[0] = 8'h12;
        tick();
        req_valid[0] = 1'b0;
        check_eq("m0_p_en", 32'(p_ram_en[0]), 32'h1);
        check_eq("m0_p_addr", 32'(p_ram_addr[0]), 32'h12);
        check_eq("m0_v_en", 32'(v_ram_en[0]), 32'h0);
        check_eq("m0_ready_low", 32'(req_ready[0]), 32'h0);
        tick();
        check_eq("m0_en_one_cycle", 32'(p_ram_en[0]), 32'h0);
        check_eq("m0_not_yet_valid", 32'(instruction_valid[0]), 32'h0);
        tick();
        check_eq("m0_valid", 32'(instruction_valid[0]), 32'h1);
        check_eq("m0_instr", 32'(instruction[0]), 32'hBEEF);
        check_eq("m0_peek_load_untouched", 32'({peek[0], load[0]}), 32'h0);
        resp_ready[0] = 1'b1;
        tick();
        resp_ready[0] = 1'b0;
        check_eq("m0_valid_cleared", 32'(instruction_valid[0]), 32'h0);
        check_eq("m0_instr_held", 32'(instruction[0]), 32'hBEEF);
        check_eq("m0_ready_back", 32'(req_ready[0]), 32'h1);

        // ---- mode 3, addr 0x40, latency 3, delayed acknowledge ----
        req_valid[1] = 1'b1; req_mode[1] = 3'd3; req_addr[1] = 8'h40;
        tick();
        req_valid[1] = 1'b0;
        check_eq("m3_v_addr", 32'(v_ram_addr[1]), 32'h40);
        pcnt = int'(p_ram_en[1]);
        vcnt = int'(v_ram_en[1]);
        n = 0;
        while (!load_valid[1] && n < 20) begin
            tick();
            n++;
            pcnt += int'(p_ram_en[1]);
            vcnt += int'(v_ram_en[1]);
        end
        check_eq("m3_accept_to_valid", 32'(n), 32'd4);
        check_eq("m3_load", 32'(load[1]), 32'h1234);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            hold_ok &= load_valid[1];
            pcnt += int'(p_ram_en[1]);
            vcnt += int'(v_ram_en[1]);
        end
        check_eq("m3_valid_held", 32'(hold_ok), 32'h1);
        resp_ready[1] = 1'b1;
        tick();
        resp_ready[1] = 1'b0;
        check_eq("m3_valid_dropped", 32'(load_valid[1]), 32'h0);
        check_eq("m3_load_held", 32'(load[1]), 32'h1234);
        check_eq("m3_v_en_pulses", 32'(vcnt), 32'd1);
        check_eq("m3_p_en_pulses", 32'(pcnt), 32'd0);

        // ---- modes 1 then 2 back to back, latency 3, resp_ready high ----
        resp_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_mode[1] = 3'd1; req_addr[1] = 8'h21;
        acc1 = -1; acc2 = -1; zeros = 0; pv = 0; lv = 0;
        for (int c = 1; c <= 25; c++) begin
            logic pre;
            pre = req_ready[1];
            tick();
            if (pre && req_valid[1]) begin
                if (acc1 < 0) begin
                    acc1 = c;
                    req_mode[1] = 3'd2;
                    req_addr[1] = 8'h22;
                end else begin
                    acc2 = c;
                    req_valid[1] = 1'b0;
                end
            end
            if (acc1 >= 0 && acc2 < 0 && !req_ready[1]) zeros++;
            pv += int'(peek_valid[1]);
            lv += int'(load_valid[1]);
        end
        resp_ready[1] = 1'b0;
        check_eq("b2b_gap", 32'(acc2 - acc1), 32'd6);
        check_eq("b2b_ready_low_cycles", 32'(zeros), 32'd5);
        check_eq("b2b_peek_valid_cycles", 32'(pv), 32'd1);
        check_eq("b2b_load_valid_cycles", 32'(lv), 32'd1);
        check_eq("b2b_peek", 32'(peek[1]), 32'h1111);
        check_eq("b2b_load", 32'(load[1]), 32'h2222);
        check_eq("b2b_instr_untouched", 32'(instruction[1]), 32'h0);

        // ---- illegal mode 6, latency 1 ----
        req_valid[0] = 1'b1; req_mode[0] = 3'd6; req_addr[0] = 8'h33;
        tick();
        req_valid[0] = 1'b0;
        merr = int'(mode_err[0]);
        check_eq("m6_mode_err_issue", 32'(mode_err[0]), 32'h1);
        check_eq("m6_p_en", 32'({p_ram_en[0], v_ram_en[0]}), 32'h2);
        tick();
        merr += int'(mode_err[0]);
        tick();
        merr += int'(mode_err[0]);
        check_eq("m6_mode_err_pulses", 32'(merr), 32'd1);
        check_eq("m6_instr_valid", 32'(instruction_valid[0]), 32'h1);
        check_eq("m6_instr", 32'(instruction[0]), 32'h00AA);
        resp_ready[0] = 1'b1;
        tick();
        resp_ready[0] = 1'b0;
        check_eq("m6_ack", 32'(instruction_valid[0]), 32'h0);

        // ---- reset during WAIT, latency 3 ----
        req_valid[1] = 1'b1; req_mode[1] = 3'd1; req_addr[1] = 8'h50;
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        check_eq("abort_ready", 32'(req_ready[1]), 32'h1);
        check_eq("abort_peek_cleared", 32'({peek_valid[1], peek[1]}), 32'h0);
        #2;
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            quiet &= ~(instruction_valid[1] | peek_valid[1] | load_valid[1]);
        end
        check_eq("abort_no_valid", 32'(quiet), 32'h1);
        check_eq("abort_stale_not_captured", 32'(peek[1]), 32'h0);
        check_eq("abort_idle_ready", 32'(req_ready[1]), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
